// File: rtl/rr_request_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the round-robin request arbiter.
package rr_request_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int HOLD_W  = 8;

    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/rr_request_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_request_arbiter_if;
    import rr_request_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic               addr0;
    logic               addr1;
    logic               enable;
    logic               timeout;

    modport master (
        output req,
        output done,
        input  addr0,
        input  addr1,
        input  enable,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output addr0,
        output addr1,
        output enable,
        output timeout
    );

endinterface

// File: rtl/rr_request_arbiter_pick.sv
// Combinational round-robin pick: first set request scanning from ptr upward, modulo 4.
module rr_priority_pick
    import rr_request_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset back to ptr so the nearest set bit wins.
    always_comb begin
        idx  = ptr;
        any  = 1'b0;
        cand = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_request_arbiter.sv
// Four-requester round-robin arbiter with hold limit; drives a 2-to-4 enable decoder.
//   state    | meaning
//   ST_IDLE  | no grant; enable low, searching from ptr
//   ST_GRANT | index held on addr1/addr0, enable high, hold_cnt running
module rr_request_arbiter
    import rr_request_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 15
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    rr_request_arbiter_if.slave  bus
);

    localparam bit                LIMIT_EN  = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = LIMIT_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              timeout_q, timeout_d;

    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic              rel_done, rel_drop, rel_limit;

    rr_priority_pick u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        rel_done   = 1'b0;
        rel_drop   = 1'b0;
        rel_limit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    idx_d      = pick_idx;
                    hold_cnt_d = '0;
                    state_d    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                rel_done  = bus.done;
                rel_drop  = ~bus.req[idx_q];
                rel_limit = LIMIT_EN && (hold_cnt_q == HOLD_LAST);
                if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
                // Timeout flags only a release the holder did not ask for itself.
                if (rel_done || rel_drop || rel_limit) begin
                    state_d   = ST_IDLE;
                    ptr_d     = idx_inc(idx_q);
                    timeout_d = rel_limit & ~rel_done & ~rel_drop;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.addr0   = idx_q[0];
    assign bus.addr1   = idx_q[1];
    assign bus.enable  = (state_q == ST_GRANT);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_request_arbiter.sv
// Bench for rr_request_arbiter: per-cycle vector table plus reset-mid-grant and no-limit sequences.
module tb_rr_request_arbiter;
    import rr_request_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_request_arbiter_if bus ();
    rr_request_arbiter_if nl_bus ();

    rr_request_arbiter #(.MAX_HOLD(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rr_request_arbiter #(.MAX_HOLD(0)) u_dut_nl (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (nl_bus)
    );

    assign nl_bus.req  = bus.req;
    assign nl_bus.done = bus.done;

    // Behavioural and structural 2-to-4 enable decoders fed by the arbiter.
    logic [1:0] g_idx;
    logic [3:0] dec_beh, dec_str;
    assign g_idx = {bus.addr1, bus.addr0};

    always_comb begin
        dec_beh = '0;
        if (bus.enable) dec_beh[g_idx] = 1'b1;
    end

    assign dec_str[0] = bus.enable & ~bus.addr1 & ~bus.addr0;
    assign dec_str[1] = bus.enable & ~bus.addr1 &  bus.addr0;
    assign dec_str[2] = bus.enable &  bus.addr1 & ~bus.addr0;
    assign dec_str[3] = bus.enable &  bus.addr1 &  bus.addr0;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       done;
        logic       en;
        logic [1:0] idx;
        logic       to;
        logic       chk_nl;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic r, input logic [3:0] rq, input logic d,
                       input logic en, input logic [1:0] ix, input logic to,
                       input logic nl);
        vec_t v;
        v.rst_n = r; v.req = rq; v.done = d;
        v.en = en; v.idx = ix; v.to = to; v.chk_nl = nl;
        vq.push_back(v);
    endtask

    task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic en, input logic [1:0] ix, input logic to);
        logic [3:0] onehot;
        onehot = en ? (4'b0001 << ix) : 4'b0000;
        check1({tag, " enable"},  8'(bus.enable), 8'(en));
        check1({tag, " index"},   8'(g_idx), 8'(ix));
        check1({tag, " timeout"}, 8'(bus.timeout), 8'(to));
        check1({tag, " dec_beh"}, 8'(dec_beh), 8'(onehot));
        check1({tag, " dec_str"}, 8'(dec_str), 8'(onehot));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_nl_to;
        bus.req  = 4'b0000;
        bus.done = 1'b0;

        // rst, req, done | en, idx, timeout, check no-limit instance
        add(0, 4'b1111, 0, 0, 2'd0, 0, 0);
        add(0, 4'b1111, 0, 0, 2'd0, 0, 0);
        add(0, 4'b1111, 0, 0, 2'd0, 0, 0);
        add(1, 4'b0100, 0, 1, 2'd2, 0, 0);
        add(1, 4'b0100, 1, 0, 2'd2, 0, 0);
        add(1, 4'b1111, 0, 1, 2'd3, 0, 0);
        add(1, 4'b1111, 0, 1, 2'd3, 0, 0);
        add(1, 4'b1111, 1, 0, 2'd3, 0, 0);
        for (int g = 0; g < 5; g++) begin
            add(1, 4'b1111, 0, 1, 2'(g), 0, 0);
            add(1, 4'b1111, 0, 1, 2'(g), 0, 0);
            add(1, 4'b1111, 1, 0, 2'(g), 0, 0);
        end
        // forced release after 4 cycles, then immediate regrant of the sole requester
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0010, 0, 0, 2'd1, 1, 1);
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0010, 1, 0, 2'd1, 0, 0);
        // requester drops its line mid-grant
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0000, 0, 0, 2'd1, 0, 0);
        // other lines toggling, then drop coinciding with the hold limit
        add(1, 4'b0010, 0, 1, 2'd1, 0, 0);
        add(1, 4'b1111, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0011, 0, 1, 2'd1, 0, 0);
        add(1, 4'b1110, 0, 1, 2'd1, 0, 0);
        add(1, 4'b0101, 0, 0, 2'd1, 0, 0);
        // index 3 wraps pointer to 0
        add(1, 4'b1000, 0, 1, 2'd3, 0, 0);
        add(1, 4'b1000, 1, 0, 2'd3, 0, 0);
        add(1, 4'b1001, 0, 1, 2'd0, 0, 0);
        add(1, 4'b1001, 0, 1, 2'd0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            rst_n    = vq[i].rst_n;
            bus.req  = vq[i].req;
            bus.done = vq[i].done;
            @(posedge clk);
            #1;
            check_out($sformatf("v%0d", i), vq[i].en, vq[i].idx, vq[i].to);
            if (vq[i].chk_nl) begin
                check1($sformatf("v%0d nolimit enable", i), 8'(nl_bus.enable), 8'd1);
                check1($sformatf("v%0d nolimit timeout", i), 8'(nl_bus.timeout), 8'd0);
            end
        end

        // asynchronous reset in the middle of a grant, no clock edge involved
        bus.done = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 2'd0, 1'b0);
        check1("async_rst nolimit enable", 8'(nl_bus.enable), 8'd0);

        bus.req = 4'b1000;
        repeat (2) @(posedge clk);
        #1;
        check_out("rst_held", 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_rst_grant", 1'b1, 2'd3, 1'b0);
        check1("post_rst nolimit enable", 8'(nl_bus.enable), 8'd1);

        // MAX_HOLD=0 holds indefinitely, well past hold_cnt saturation
        saw_nl_to = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            if (nl_bus.timeout) saw_nl_to = 1'b1;
        end
        check1("nolimit long enable", 8'(nl_bus.enable), 8'd1);
        check1("nolimit long index", 8'({nl_bus.addr1, nl_bus.addr0}), 8'd3);
        check1("nolimit long no timeout", 8'(saw_nl_to), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
